// File: rtl/rgb_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb_stream_pkg
// Description : Shared definitions for the RGB565 stream transmitter:
//               FSM state encoding, pixel type and timing-geometry helpers.
// Contents    : c_pix_w, pixel_t, c_st_* states, f_total(), f_act_s()
// Revision    : 1.0 - initial release
// ============================================================================
package rgb_stream_pkg;

    localparam int c_pix_w = 16;
    typedef logic [c_pix_w-1:0] pixel_t;

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_run       = 2'd1;
    localparam logic [1:0] c_st_stop_pend = 2'd2;

    // Full period of one axis (line in clocks, or frame in lines).
    function automatic logic [11:0] f_total(input logic [11:0] sync,
                                            input logic [11:0] back,
                                            input logic [11:0] disp,
                                            input logic [11:0] front);
        return sync + back + disp + front;
    endfunction

    // First active position of one axis.
    function automatic logic [11:0] f_act_s(input logic [11:0] sync,
                                            input logic [11:0] back);
        return sync + back;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_stream_tx_vid_timing_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vid_timing_cnt
// Description : Horizontal/vertical position counters and stage-0 timing
//               decode for the RGB stream transmitter.
// Ports       : clk, rst_n      - clock, async active-low reset
//               run             - advance the counters
//               clear           - force counters to (0,0)
//               hs0, vs0, act0  - decoded sync/active, zero when not running
//               frame_last      - counters sit at the last position of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module vid_timing_cnt
    import rgb_stream_pkg::*;
#(
    parameter logic [11:0] H_DISP  = 12'd480,
    parameter logic [11:0] V_DISP  = 12'd272,
    parameter logic [11:0] H_SYNC  = 12'd41,
    parameter logic [11:0] H_BACK  = 12'd2,
    parameter logic [11:0] H_FRONT = 12'd2,
    parameter logic [11:0] V_SYNC  = 12'd10,
    parameter logic [11:0] V_BACK  = 12'd2,
    parameter logic [11:0] V_FRONT = 12'd2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic hs0,
    output logic vs0,
    output logic act0,
    output logic frame_last
);

    localparam logic [11:0] c_h_total = f_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam logic [11:0] c_v_total = f_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
    localparam logic [11:0] c_h_act_s = f_act_s(H_SYNC, H_BACK);
    localparam logic [11:0] c_v_act_s = f_act_s(V_SYNC, V_BACK);
    localparam logic [11:0] c_h_act_e = c_h_act_s + H_DISP;
    localparam logic [11:0] c_v_act_e = c_v_act_s + V_DISP;
    localparam logic [11:0] c_h_last  = c_h_total - 12'd1;
    localparam logic [11:0] c_v_last  = c_v_total - 12'd1;

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic        w_h_wrap;
    logic        w_v_wrap;

    assign w_h_wrap = (r_h_cnt == c_h_last);
    assign w_v_wrap = (r_v_cnt == c_v_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (clear) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (run) begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_wrap ? 12'd0 : r_v_cnt + 12'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 12'd1;
            end
        end
    end

    // (0,0) decodes as a sync position, so gate with run to keep the
    // outputs quiet while idle.
    assign hs0  = run & (r_h_cnt < H_SYNC);
    assign vs0  = run & (r_v_cnt < V_SYNC);
    assign act0 = run & (r_h_cnt >= c_h_act_s) & (r_h_cnt < c_h_act_e)
                      & (r_v_cnt >= c_v_act_s) & (r_v_cnt < c_v_act_e);
    assign frame_last = run & w_h_wrap & w_v_wrap;

endmodule
`default_nettype wire

// File: rtl/rgb_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : rgb_stream_tx
// Description : RGB565 video stream transmitter. Pops pixels from a
//               show-behind FIFO and drives LCD-style hsync/vsync/de/data
//               with a two-stage output pipeline; flags FIFO underflow.
// Ports       : clk, rst_n           - pixel clock, async active-low reset
//               en                   - stream enable
//               fifo_empty/rd_en/rd_data - upstream FIFO handshake
//               RGB_hsync/vsync/data/de  - video stream outputs
//               underflow            - sticky per-frame starvation flag
//               busy                 - running or pipeline still draining
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_stream_tx
    import rgb_stream_pkg::*;
#(
    parameter logic [11:0] H_DISP  = 12'd480,
    parameter logic [11:0] V_DISP  = 12'd272,
    parameter logic [11:0] H_SYNC  = 12'd41,
    parameter logic [11:0] H_BACK  = 12'd2,
    parameter logic [11:0] H_FRONT = 12'd2,
    parameter logic [11:0] V_SYNC  = 12'd10,
    parameter logic [11:0] V_BACK  = 12'd2,
    parameter logic [11:0] V_FRONT = 12'd2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  pixel_t       fifo_rd_data,
    output logic         RGB_hsync,
    output logic         RGB_vsync,
    output pixel_t       RGB_data,
    output logic         RGB_de,
    output logic         underflow,
    output logic         busy
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_run;
    logic       w_hs0, w_vs0, w_act0, w_frame_last;

    logic       r_hs1, r_vs1, r_act1, r_starve1, r_vld1, r_vld2;
    logic       r_hsync, r_vsync, r_de, r_underflow;
    pixel_t     r_data;
    logic       w_starve2;

    assign w_run = (r_state == c_st_run) | (r_state == c_st_stop_pend);

    vid_timing_cnt #(
        .H_DISP (H_DISP),  .V_DISP (V_DISP),
        .H_SYNC (H_SYNC),  .H_BACK (H_BACK),  .H_FRONT (H_FRONT),
        .V_SYNC (V_SYNC),  .V_BACK (V_BACK),  .V_FRONT (V_FRONT)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (w_run),
        .clear      (~w_run),
        .hs0        (w_hs0),
        .vs0        (w_vs0),
        .act0       (w_act0),
        .frame_last (w_frame_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:      if (en) w_state_nxt = c_st_run;
            c_st_run:       if (!en) w_state_nxt = c_st_stop_pend;
            c_st_stop_pend: begin
                if (w_frame_last) w_state_nxt = en ? c_st_run : c_st_idle;
                else if (en)      w_state_nxt = c_st_run;
            end
            default:        w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    // Starved pixels are skipped, never stalled: the timing keeps running.
    assign fifo_rd_en = w_act0 & ~fifo_empty;

    // rd_data arrives one cycle after the pop, i.e. alongside stage 1.
    assign w_starve2 = r_act1 & r_starve1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs1       <= 1'b0;
            r_vs1       <= 1'b0;
            r_act1      <= 1'b0;
            r_starve1   <= 1'b0;
            r_vld1      <= 1'b0;
            r_vld2      <= 1'b0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
            r_de        <= 1'b0;
            r_data      <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_hs1     <= w_hs0;
            r_vs1     <= w_vs0;
            r_act1    <= w_act0;
            r_starve1 <= w_act0 & fifo_empty;
            r_vld1    <= w_run;
            r_vld2    <= r_vld1;
            r_hsync   <= r_hs1;
            r_vsync   <= r_vs1;
            r_de      <= r_act1;
            r_data    <= (r_act1 & ~r_starve1) ? fifo_rd_data : '0;
            // New frame (vsync rising) restarts the flag, but a starved
            // pixel in that same cycle still sets it.
            if (r_vs1 & ~r_vsync) r_underflow <= w_starve2;
            else                  r_underflow <= r_underflow | w_starve2;
        end
    end

    assign RGB_hsync = r_hsync;
    assign RGB_vsync = r_vsync;
    assign RGB_de    = r_de;
    assign RGB_data  = r_data;
    assign underflow = r_underflow;
    assign busy      = w_run | r_vld1 | r_vld2;

endmodule
`default_nettype wire

// File: tb/tb_rgb_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_stream_tx
// Description : Directed self-checking bench for rgb_stream_tx using a small
//               8x4 geometry (H_TOTAL=12, V_TOTAL=8) and a counting FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_stream_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data = 16'h0000;
    logic        RGB_hsync, RGB_vsync, RGB_de, underflow, busy;
    logic [15:0] RGB_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] fifo_ptr = 16'h0000;

    always #5 clk = ~clk;

    // Show-behind FIFO holding 0,1,2,...: data follows the pop by one clock.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_ptr;
            fifo_ptr     <= fifo_ptr + 16'd1;
        end
    end

    rgb_stream_tx #(
        .H_DISP (12'd8), .V_DISP (12'd4),
        .H_SYNC (12'd2), .H_BACK (12'd1), .H_FRONT (12'd1),
        .V_SYNC (12'd2), .V_BACK (12'd1), .V_FRONT (12'd1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .RGB_hsync    (RGB_hsync),
        .RGB_vsync    (RGB_vsync),
        .RGB_data     (RGB_data),
        .RGB_de       (RGB_de),
        .underflow    (underflow),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Geometry of the 12x8 test frame, by linear position k = v*12 + h.
    function automatic logic act_at(input int k);
        int h, v;
        h = k % 12;
        v = k / 12;
        return (h >= 3) && (h < 11) && (v >= 3) && (v < 7);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hsync"}, 32'(RGB_hsync), 32'd0);
        chk({tag, "_vsync"}, 32'(RGB_vsync), 32'd0);
        chk({tag, "_de"},    32'(RGB_de),    32'd0);
        chk({tag, "_data"},  32'(RGB_data),  32'd0);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        logic [15:0] exp_pix;
        logic [15:0] e_data;
        logic        uf, st;
        int          pops, n;

        exp_pix    = 16'h0000;
        uf         = 1'b0;
        rst_n      = 1'b0;
        en         = 1'b0;
        fifo_empty = 1'b0;

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        chk("reset_underflow", 32'(underflow), 32'd0);

        // Released but not enabled: stays idle
        rst_n = 1'b1;
        repeat (3) tick();
        chk_all_zero("idle");

        // Enable: RUN next edge, counters at (0,0), outputs lag by 2
        en = 1'b1;
        tick();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_hsync_lag", 32'(RGB_hsync), 32'd0);
        tick();
        tick();

        // Three frames: clean, 3-pixel starvation on line 5, en dropped on line 3
        for (int f = 0; f < 3; f++) begin
            pops = 0;
            for (int idx = 0; idx < 96; idx++) begin
                // outputs now show frame position idx
                st = (f == 1) && (idx >= 65) && (idx <= 67);
                if (idx == 0) uf = st;
                else          uf = uf | st;
                if (act_at(idx) && !st) begin
                    e_data  = exp_pix;
                    exp_pix = exp_pix + 16'd1;
                end else begin
                    e_data = 16'h0000;
                end
                chk("hsync", 32'(RGB_hsync), 32'((idx % 12) < 2));
                chk("vsync", 32'(RGB_vsync), 32'((idx / 12) < 2));
                chk("de",    32'(RGB_de),    32'(act_at(idx)));
                chk("data",  32'(RGB_data),  32'(e_data));
                chk("underflow", 32'(underflow), 32'(uf));
                chk("busy_run",  32'(busy),  32'd1);

                // counters sit two positions ahead of the outputs
                n = (idx + 2) % 96;
                if (f == 2 && idx == 40) en = 1'b0;
                fifo_empty = (f == 1) && (idx + 2 >= 65) && (idx + 2 <= 67);
                #1;
                chk("rd_en", 32'(fifo_rd_en), 32'(act_at(n) && !fifo_empty));
                if (fifo_rd_en) pops++;
                tick();
            end
            chk("pops_per_frame", 32'(pops), (f == 1) ? 32'd29 : 32'd32);
        end

        // Frame finished after en dropped: wrap + 2 cycles, all quiet
        chk_all_zero("stopped");
        chk("stopped_underflow", 32'(underflow), 32'd0);

        // Restart: hsync/vsync appear 2 clocks after counters reach (0,0)
        en = 1'b1;
        tick();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_hsync0", 32'(RGB_hsync), 32'd0);
        tick();
        chk("restart_hsync1", 32'(RGB_hsync), 32'd0);
        tick();
        chk("restart_hsync2", 32'(RGB_hsync), 32'd1);
        chk("restart_vsync2", 32'(RGB_vsync), 32'd1);
        chk("restart_de2",    32'(RGB_de),    32'd0);

        // Move into DE, then reset asynchronously mid-cycle
        repeat (40) tick();
        chk("pre_reset_de", 32'(RGB_de), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_all_zero("post_reset_idle");
        en = 1'b1;
        tick();
        chk("post_reset_start_busy", 32'(busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
